// File: rtl/misc_v_pkg.sv
// Shared encodings for the execute stage: ALU opcodes, forwarding selects, FSM state.
package misc_v_pkg;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOr  = 3'b011;
  localparam logic [2:0] AluXor = 3'b100;
  localparam logic [2:0] AluSll = 3'b101;
  localparam logic [2:0] AluSrl = 3'b110;
  localparam logic [2:0] AluMul = 3'b111;

  // Operand A/B forwarding select
  localparam logic [1:0] FwdMem  = 2'd0;
  localparam logic [1:0] FwdWb   = 2'd1;
  localparam logic [1:0] FwdIdex = 2'd2;
  localparam logic [1:0] FwdZero = 2'd3;

  // Store-data (arg3) forwarding select
  localparam logic Fwd3Wb   = 1'b0;
  localparam logic Fwd3Idex = 1'b1;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} exState_e;

  function automatic logic isMulOp(input logic [2:0] op);
    return op == AluMul;
  endfunction

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier: one partial-product step per clock, low Width bits kept.
module mul_iter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [Width-1:0] a,
  input  logic [Width-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [Width-1:0] product
);

  localparam int unsigned CntW = $clog2(Width + 1);

  logic [Width-1:0] aQ, bQ, prodQ;
  logic [CntW-1:0]  cntQ;

  // Operand/accumulator registers; abort drops the count so no further steps occur
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      aQ    <= '0;
      bQ    <= '0;
      prodQ <= '0;
      cntQ  <= '0;
    end else if (abort) begin
      cntQ <= '0;
    end else if (start) begin
      aQ    <= a;
      bQ    <= b;
      prodQ <= '0;
      cntQ  <= CntW'(Width);
    end else if (cntQ != '0) begin
      if (bQ[0]) prodQ <= prodQ + aQ;
      aQ   <= aQ << 1;
      bQ   <= bQ >> 1;
      cntQ <= cntQ - 1'b1;
    end
  end

  // done flags the edge that performs the final step, so the caller can leave BUSY on it
  always_comb begin
    busy    = (cntQ != '0);
    done    = (cntQ == CntW'(1));
    product = prodQ;
  end

endmodule

// File: rtl/exec_stage_mc.sv
// Execute stage: ID/EX register, operand forwarding, single-cycle ALU and an
// iterative multiplier that stalls the stage while it runs.
module exec_stage_mc
  import misc_v_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned REGW  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_flush,
  input  logic             i_regwrite,
  input  logic             i_alusrc,
  input  logic             i_memwrite,
  input  logic             i_memread,
  input  logic [2:0]       i_aluop,
  input  logic [1:0]       i_regstore,
  input  logic [WIDTH-1:0] i_pcp2,
  input  logic [WIDTH-1:0] i_arg1,
  input  logic [WIDTH-1:0] i_arg2,
  input  logic [WIDTH-1:0] i_arg3,
  input  logic [WIDTH-1:0] i_imm,
  input  logic [REGW-1:0]  i_rs1,
  input  logic [REGW-1:0]  i_rs2,
  input  logic [REGW-1:0]  i_rd,
  input  logic [WIDTH-1:0] fwd_mem,
  input  logic [WIDTH-1:0] fwd_wb,
  input  logic [1:0]       fwd1_sel,
  input  logic [1:0]       fwd2_sel,
  input  logic             fwd3_sel,
  output logic             o_valid,
  output logic             o_regwrite,
  output logic             o_memwrite,
  output logic             o_memread,
  output logic [1:0]       o_regstore,
  output logic [WIDTH-1:0] o_pcp2,
  output logic [WIDTH-1:0] o_result,
  output logic [WIDTH-1:0] o_arg3,
  output logic [REGW-1:0]  o_rs1,
  output logic [REGW-1:0]  o_rs2,
  output logic [REGW-1:0]  o_rd
);

  localparam int unsigned ShW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef struct packed {
    logic             valid;
    logic             regwrite;
    logic             alusrc;
    logic             memwrite;
    logic             memread;
    logic [2:0]       aluop;
    logic [1:0]       regstore;
    logic [WIDTH-1:0] pcp2;
    logic [WIDTH-1:0] arg1;
    logic [WIDTH-1:0] arg2;
    logic [WIDTH-1:0] arg3;
    logic [WIDTH-1:0] imm;
    logic [REGW-1:0]  rs1;
    logic [REGW-1:0]  rs2;
    logic [REGW-1:0]  rd;
  } idex_t;

  idex_t            idexQ, idexD;
  exState_e         stateQ, stateD;
  logic             isMul, mulStart, mulBusy, mulDone, valid;
  logic [WIDTH-1:0] opA, fwdB, opB, aluRes, mulProduct;

  // ID/EX next value: flush beats capture, a non-valid capture is an all-zero bubble
  always_comb begin
    idexD = idexQ;
    if (i_flush) begin
      idexD = '0;
    end else if (o_ready) begin
      if (i_valid) begin
        idexD = '{valid: 1'b1, regwrite: i_regwrite, alusrc: i_alusrc, memwrite: i_memwrite,
                  memread: i_memread, aluop: i_aluop, regstore: i_regstore, pcp2: i_pcp2,
                  arg1: i_arg1, arg2: i_arg2, arg3: i_arg3, imm: i_imm, rs1: i_rs1,
                  rs2: i_rs2, rd: i_rd};
      end else begin
        idexD = '0;
      end
    end
  end

  // ID/EX and FSM state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idexQ  <= '0;
      stateQ <= StIdle;
    end else begin
      idexQ  <= idexD;
      stateQ <= stateD;
    end
  end

  // Operand forwarding muxes
  always_comb begin
    unique case (fwd1_sel)
      FwdMem:  opA = fwd_mem;
      FwdWb:   opA = fwd_wb;
      FwdIdex: opA = idexQ.arg1;
      default: opA = '0;
    endcase
    unique case (fwd2_sel)
      FwdMem:  fwdB = fwd_mem;
      FwdWb:   fwdB = fwd_wb;
      FwdIdex: fwdB = idexQ.arg2;
      default: fwdB = '0;
    endcase
    opB = idexQ.alusrc ? idexQ.imm : fwdB;
  end

  // Single-cycle ALU; multiply result comes from mul_iter instead
  always_comb begin
    unique case (idexQ.aluop)
      AluAdd:  aluRes = opA + opB;
      AluSub:  aluRes = opA - opB;
      AluAnd:  aluRes = opA & opB;
      AluOr:   aluRes = opA | opB;
      AluXor:  aluRes = opA ^ opB;
      AluSll:  aluRes = opA << opB[ShW-1:0];
      AluSrl:  aluRes = opA >> opB[ShW-1:0];
      default: aluRes = '0;
    endcase
  end

  // FSM next state, multiplier start and stage handshake
  always_comb begin
    isMul    = idexQ.valid && isMulOp(idexQ.aluop);
    stateD   = stateQ;
    mulStart = 1'b0;
    unique case (stateQ)
      StIdle: begin
        if (isMul) begin
          mulStart = 1'b1;
          stateD   = StBusy;
        end
      end
      StBusy: begin
        if (mulDone)       stateD = StDone;
        else if (!mulBusy) stateD = StIdle;  // multiplier lost its job; do not hang
      end
      StDone:  stateD = StIdle;
      default: stateD = StIdle;
    endcase
    if (i_flush) begin
      stateD   = StIdle;
      mulStart = 1'b0;
    end
    o_ready = ((stateQ == StIdle) && !isMul) || (stateQ == StDone);
    valid   = ((stateQ == StIdle) && idexQ.valid && !isMul) || (stateQ == StDone);
  end

  mul_iter #(
    .Width(WIDTH)
  ) u_mul (
    .clk    (clk),
    .reset  (reset),
    .start  (mulStart),
    .abort  (i_flush),
    .a      (opA),
    .b      (opB),
    .busy   (mulBusy),
    .done   (mulDone),
    .product(mulProduct)
  );

  // Outputs; data that depends on live forwarding is zeroed when nothing is valid
  always_comb begin
    o_valid    = valid;
    o_regwrite = idexQ.regwrite & valid;
    o_memwrite = idexQ.memwrite & valid;
    o_memread  = idexQ.memread & valid;
    o_regstore = idexQ.regstore;
    o_pcp2     = idexQ.pcp2;
    o_rs1      = idexQ.rs1;
    o_rs2      = idexQ.rs2;
    o_rd       = idexQ.rd;
    o_result   = '0;
    o_arg3     = '0;
    if (valid) begin
      o_result = (stateQ == StDone) ? mulProduct : aluRes;
      o_arg3   = (fwd3_sel == Fwd3Idex) ? idexQ.arg3 : fwd_wb;
    end
  end

endmodule

// File: tb/tb_exec_stage_mc.sv
// Directed bench for exec_stage_mc: vector table for single-cycle ops, hand
// sequences for multiply latency, flush, reset abort and an 8-bit instance.
module tb_exec_stage_mc;

  logic        clk = 1'b0;
  logic        reset;
  logic        iValid, iFlush, iRegwrite, iAlusrc, iMemwrite, iMemread;
  logic [2:0]  iAluop;
  logic [1:0]  iRegstore;
  logic [15:0] iPcp2, iArg1, iArg2, iArg3, iImm, fwdMem, fwdWb;
  logic [2:0]  iRs1, iRs2, iRd;
  logic [1:0]  fwd1Sel, fwd2Sel;
  logic        fwd3Sel;
  logic        oReady, oValid, oRegwrite, oMemwrite, oMemread;
  logic [1:0]  oRegstore;
  logic [15:0] oPcp2, oResult, oArg3;
  logic [2:0]  oRs1, oRs2, oRd;

  logic        v8;
  logic [7:0]  a8, b8;
  logic        rdy8, val8, rw8, mw8, mr8;
  logic [1:0]  rgs8;
  logic [7:0]  pc8, res8, a3o8;
  logic [2:0]  rs18, rs28, rd8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  exec_stage_mc #(.WIDTH(16), .REGW(3)) dut (
    .clk(clk), .reset(reset), .i_valid(iValid), .o_ready(oReady), .i_flush(iFlush),
    .i_regwrite(iRegwrite), .i_alusrc(iAlusrc), .i_memwrite(iMemwrite), .i_memread(iMemread),
    .i_aluop(iAluop), .i_regstore(iRegstore), .i_pcp2(iPcp2), .i_arg1(iArg1), .i_arg2(iArg2),
    .i_arg3(iArg3), .i_imm(iImm), .i_rs1(iRs1), .i_rs2(iRs2), .i_rd(iRd), .fwd_mem(fwdMem),
    .fwd_wb(fwdWb), .fwd1_sel(fwd1Sel), .fwd2_sel(fwd2Sel), .fwd3_sel(fwd3Sel),
    .o_valid(oValid), .o_regwrite(oRegwrite), .o_memwrite(oMemwrite), .o_memread(oMemread),
    .o_regstore(oRegstore), .o_pcp2(oPcp2), .o_result(oResult), .o_arg3(oArg3),
    .o_rs1(oRs1), .o_rs2(oRs2), .o_rd(oRd)
  );

  exec_stage_mc #(.WIDTH(8), .REGW(3)) dut8 (
    .clk(clk), .reset(reset), .i_valid(v8), .o_ready(rdy8), .i_flush(1'b0),
    .i_regwrite(1'b1), .i_alusrc(1'b0), .i_memwrite(1'b0), .i_memread(1'b0),
    .i_aluop(3'b111), .i_regstore(2'd0), .i_pcp2(8'h00), .i_arg1(a8), .i_arg2(b8),
    .i_arg3(8'h00), .i_imm(8'h00), .i_rs1(3'd0), .i_rs2(3'd0), .i_rd(3'd0), .fwd_mem(8'h00),
    .fwd_wb(8'h00), .fwd1_sel(2'd2), .fwd2_sel(2'd2), .fwd3_sel(1'b1),
    .o_valid(val8), .o_regwrite(rw8), .o_memwrite(mw8), .o_memread(mr8),
    .o_regstore(rgs8), .o_pcp2(pc8), .o_result(res8), .o_arg3(a3o8),
    .o_rs1(rs18), .o_rs2(rs28), .o_rd(rd8)
  );

  typedef struct {
    logic [2:0]  op;
    logic        src;
    logic [1:0]  f1, f2;
    logic        f3;
    logic [15:0] a1, a2, a3, imm, mem, wb;
    logic [2:0]  ctl;  // {regwrite, memwrite, memread}
    logic [2:0]  rd;
    logic [15:0] res, arg3;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyVec(input int i);
    @(negedge clk);
    iValid = 1'b1; iAluop = vecs[i].op; iAlusrc = vecs[i].src;
    fwd1Sel = vecs[i].f1; fwd2Sel = vecs[i].f2; fwd3Sel = vecs[i].f3;
    iArg1 = vecs[i].a1; iArg2 = vecs[i].a2; iArg3 = vecs[i].a3; iImm = vecs[i].imm;
    fwdMem = vecs[i].mem; fwdWb = vecs[i].wb;
    {iRegwrite, iMemwrite, iMemread} = vecs[i].ctl;
    iRd = vecs[i].rd; iPcp2 = 16'(16'h0100 + i);
    @(posedge clk);
    #1;
    chk($sformatf("vec%0d valid", i), 16'(oValid), 16'd1);
    chk($sformatf("vec%0d ready", i), 16'(oReady), 16'd1);
    chk($sformatf("vec%0d result", i), oResult, vecs[i].res);
    chk($sformatf("vec%0d arg3", i), oArg3, vecs[i].arg3);
    chk($sformatf("vec%0d ctl", i), 16'({oRegwrite, oMemwrite, oMemread}), 16'(vecs[i].ctl));
    chk($sformatf("vec%0d rd", i), 16'(oRd), 16'(vecs[i].rd));
    chk($sformatf("vec%0d pcp2", i), oPcp2, 16'(16'h0100 + i));
  endtask

  // Drive a multiply entry; A comes from fwd_mem, B from the ID/EX arg2
  task automatic startMul(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    iValid = 1'b1; iAluop = 3'b111; iAlusrc = 1'b0;
    fwd1Sel = 2'd0; fwdMem = a; fwd2Sel = 2'd2; iArg2 = b; iArg1 = 16'hDEAD;
    fwd3Sel = 1'b1; iArg3 = 16'h0000;
    iRegwrite = 1'b1; iMemwrite = 1'b0; iMemread = 1'b0;
    iPcp2 = 16'h0ABC; iRd = 3'd5;
    @(posedge clk);
  endtask

  task automatic doMul(input logic [15:0] a, input logic [15:0] b, input logic [15:0] exp,
                       input string tag);
    int lowBad;
    lowBad = 0;
    startMul(a, b);
    for (int c = 1; c <= 17; c++) begin
      #1;
      if (oReady !== 1'b0 || oValid !== 1'b0 || oRegwrite !== 1'b0 || oResult !== 16'h0)
        lowBad++;
      @(negedge clk);
      iValid = 1'b0;
      iPcp2  = 16'h5555;
      // A and B were sampled at the start edge; disturb the forwarding paths afterwards
      if (c >= 2) begin
        fwdMem = ~fwdMem ^ 16'(c);
        iArg2  = 16'(c * 3);
      end
      @(posedge clk);
    end
    #1;
    chk({tag, " stall cycles"}, 16'(lowBad), 16'd0);
    chk({tag, " valid"}, 16'(oValid), 16'd1);
    chk({tag, " ready"}, 16'(oReady), 16'd1);
    chk({tag, " result"}, oResult, exp);
    chk({tag, " regwrite"}, 16'(oRegwrite), 16'd1);
    chk({tag, " held pcp2"}, oPcp2, 16'h0ABC);
    chk({tag, " held rd"}, 16'(oRd), 16'd5);
    @(posedge clk);
    #1;
    chk({tag, " single pulse"}, 16'(oValid), 16'd0);
  endtask

  task automatic noStrayValid(input string tag);
    int stray;
    stray = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (oValid !== 1'b0) stray++;
    end
    chk({tag, " no stray valid"}, 16'(stray), 16'd0);
  endtask

  initial begin
    //          op    src   f1    f2    f3    a1        a2        a3        imm       mem       wb        ctl     rd    res       arg3
    vecs[0] = '{3'd0, 1'b0, 2'd2, 2'd2, 1'b1, 16'h7FFF, 16'h0001, 16'h3333, 16'h0000, 16'h0000, 16'h0000, 3'b100, 3'd1, 16'h8000, 16'h3333};
    vecs[1] = '{3'd1, 1'b1, 2'd0, 2'd2, 1'b0, 16'h0000, 16'hFFFF, 16'h3333, 16'h0034, 16'h1234, 16'h5A5A, 3'b010, 3'd2, 16'h1200, 16'h5A5A};
    vecs[2] = '{3'd2, 1'b0, 2'd2, 2'd1, 1'b1, 16'hF0F0, 16'h0000, 16'h1111, 16'h0000, 16'h0000, 16'hFF00, 3'b001, 3'd3, 16'hF000, 16'h1111};
    vecs[3] = '{3'd3, 1'b0, 2'd1, 2'd2, 1'b0, 16'h0000, 16'h0F01, 16'h0000, 16'h0000, 16'h0000, 16'h00F0, 3'b111, 3'd4, 16'h0FF1, 16'h00F0};
    vecs[4] = '{3'd4, 1'b0, 2'd2, 2'd0, 1'b1, 16'hAAAA, 16'h0000, 16'h2222, 16'h0000, 16'hFFFF, 16'h0000, 3'b000, 3'd5, 16'h5555, 16'h2222};
    vecs[5] = '{3'd5, 1'b1, 2'd2, 2'd3, 1'b1, 16'h0001, 16'h0000, 16'h0000, 16'h0013, 16'h0000, 16'h0000, 3'b100, 3'd6, 16'h0008, 16'h0000};
    vecs[6] = '{3'd6, 1'b0, 2'd0, 2'd2, 1'b0, 16'h0000, 16'h000F, 16'h0000, 16'h0000, 16'h8000, 16'h7777, 3'b100, 3'd7, 16'h0001, 16'h7777};
    vecs[7] = '{3'd0, 1'b0, 2'd3, 2'd2, 1'b1, 16'hFFFF, 16'h1234, 16'h4444, 16'h0000, 16'h0000, 16'h0000, 3'b010, 3'd0, 16'h1234, 16'h4444};
    vecs[8] = '{3'd1, 1'b0, 2'd2, 2'd2, 1'b1, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 3'b100, 3'd1, 16'hFFFF, 16'h0000};
    vecs[9] = '{3'd3, 1'b0, 2'd2, 2'd3, 1'b1, 16'h00AB, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 3'b001, 3'd2, 16'h00AB, 16'h0000};

    // Live forwarding inputs nonzero during reset: outputs must still read zero
    reset = 1'b1; iValid = 1'b0; iFlush = 1'b0; iRegwrite = 1'b1; iAlusrc = 1'b0;
    iMemwrite = 1'b1; iMemread = 1'b1; iAluop = 3'd0; iRegstore = 2'd0;
    iPcp2 = 16'h0; iArg1 = 16'h0; iArg2 = 16'h0; iArg3 = 16'h0; iImm = 16'h0;
    iRs1 = 3'd0; iRs2 = 3'd0; iRd = 3'd0;
    fwdMem = 16'h1234; fwdWb = 16'h4321; fwd1Sel = 2'd0; fwd2Sel = 2'd1; fwd3Sel = 1'b0;
    v8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset valid", 16'(oValid), 16'd0);
    chk("reset ready", 16'(oReady), 16'd1);
    chk("reset result", oResult, 16'h0);
    chk("reset arg3", oArg3, 16'h0);
    chk("reset ctl", 16'({oRegwrite, oMemwrite, oMemread}), 16'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("post-reset valid", 16'(oValid), 16'd0);
    chk("post-reset ready", 16'(oReady), 16'd1);
    chk("post-reset result", oResult, 16'h0);
    chk("post-reset pcp2", oPcp2, 16'h0);

    for (int i = 0; i < 10; i++) applyVec(i);

    // Bubble capture
    @(negedge clk);
    iValid = 1'b0;
    @(posedge clk);
    #1;
    chk("bubble valid", 16'(oValid), 16'd0);
    chk("bubble ready", 16'(oReady), 16'd1);
    chk("bubble regwrite", 16'(oRegwrite), 16'd0);
    chk("bubble result", oResult, 16'h0);

    doMul(16'h00FF, 16'h0101, 16'hFFFF, "mul ff*101");
    doMul(16'hFFFF, 16'hFFFF, 16'h0001, "mul ones*ones");
    doMul(16'h0000, 16'hFFFF, 16'h0000, "mul zero*ones");

    // Flush in the 5th BUSY cycle
    startMul(16'h0003, 16'h0005);
    @(negedge clk);
    iValid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("flush pre ready", 16'(oReady), 16'd0);
    @(negedge clk);
    iFlush = 1'b1;
    @(posedge clk);
    #1;
    chk("flush valid", 16'(oValid), 16'd0);
    chk("flush ready", 16'(oReady), 16'd1);
    chk("flush rd", 16'(oRd), 16'd0);
    @(negedge clk);
    iFlush = 1'b0;
    noStrayValid("flush");
    applyVec(3);

    // Reset in the middle of a multiply
    startMul(16'h0007, 16'h0009);
    @(negedge clk);
    iValid = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midreset valid", 16'(oValid), 16'd0);
    chk("midreset ready", 16'(oReady), 16'd1);
    chk("midreset result", oResult, 16'h0);
    chk("midreset pcp2", oPcp2, 16'h0);
    chk("midreset rd", 16'(oRd), 16'd0);
    chk("midreset regwrite", 16'(oRegwrite), 16'd0);
    @(negedge clk);
    reset = 1'b0;
    noStrayValid("midreset");
    applyVec(0);

    // 8-bit instance: 0x0F * 0x11, valid expected 10 cycles after capture
    begin
      int lowBad8;
      lowBad8 = 0;
      @(negedge clk);
      v8 = 1'b1; a8 = 8'h0F; b8 = 8'h11;
      @(posedge clk);
      for (int c = 1; c <= 9; c++) begin
        #1;
        if (rdy8 !== 1'b0 || val8 !== 1'b0) lowBad8++;
        @(negedge clk);
        v8 = 1'b0;
        @(posedge clk);
      end
      #1;
      chk("w8 stall cycles", 16'(lowBad8), 16'd0);
      chk("w8 valid", 16'(val8), 16'd1);
      chk("w8 result", 16'(res8), 16'h00FF);
      chk("w8 ready", 16'(rdy8), 16'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exec_stage_mc.md
EXEC_STAGE_MC -- requirements
Module: exec_stage_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 16, datapath width (8..32).
REQ-002 SHALL have parameter REGW, default 3, register-index width.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high.
REQ-005 SHALL have port i_valid  input  1  ID-stage instruction present.
REQ-006 SHALL have port o_ready  output  1  stage accepts a new instruction this cycle.
REQ-007 SHALL have port i_flush  input  1  kill the ID/EX entry.
REQ-008 SHALL have ports i_regwrite, i_alusrc, i_memwrite, i_memread  input  1 each  decode controls.
REQ-009 SHALL have ports i_aluop  input  3 and i_regstore  input  2  decode controls.
REQ-010 SHALL have ports i_pcp2, i_arg1, i_arg2, i_arg3, i_imm  input  WIDTH  operands.
REQ-011 SHALL have ports i_rs1, i_rs2, i_rd  input  REGW  register indices.
REQ-012 SHALL have ports fwd_mem, fwd_wb  input  WIDTH  forwarded MEM ALU result and WB load data.
REQ-013 SHALL have ports fwd1_sel, fwd2_sel  input  2 (0 MEM, 1 WB, 2 ID/EX value, 3 zero) and fwd3_sel  input  1 (0 WB, 1 ID/EX value).
REQ-014 SHALL have port o_valid  output  1  EX result valid this cycle.
REQ-015 SHALL have ports o_regwrite, o_memwrite, o_memread  output  1; o_regstore  output  2.
REQ-016 SHALL have ports o_pcp2, o_result, o_arg3  output  WIDTH; o_rs1, o_rs2, o_rd  output  REGW.

Function
REQ-017 SHALL capture all i_* fields into the ID/EX register on a rising edge when o_ready=1; i_valid=0 captures a bubble.
REQ-018 SHALL hold the ID/EX register unchanged while o_ready=0.
REQ-019 SHALL select ALU operand A by fwd1_sel, operand B by i_alusrc (1: imm, 0: fwd2_sel mux), o_arg3 by fwd3_sel.
REQ-020 SHALL implement aluop 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 sll, 110 srl (shift by low clog2(WIDTH) bits of B), all modulo 2^WIDTH, zero latency from the ID/EX register.
REQ-021 SHALL implement aluop 111 as multiply, result = low WIDTH bits of A*B, iterative one bit per cycle.
REQ-022 SHALL use FSM states IDLE, BUSY, DONE.
REQ-023 IDLE with a valid non-multiply entry: o_valid=1, o_ready=1, result combinational.
REQ-024 IDLE with a valid multiply entry: o_valid=0, o_ready=0; at the next edge latch forwarded A and B into the multiplier, counter=WIDTH, state BUSY.
REQ-025 BUSY: one shift-add step per edge, counter decrements; o_valid=0, o_ready=0; at counter reaching 0, state DONE.
REQ-026 DONE: o_valid=1, o_result=product, o_ready=1; next edge state IDLE.
REQ-027 Multiply latency SHALL therefore be WIDTH+2 cycles from capture edge to o_valid.
REQ-028 Forwarding inputs SHALL be sampled only once per multiply (REQ-024); later changes SHALL NOT affect the product.
REQ-029 o_regwrite, o_memwrite, o_memread SHALL be ANDed with o_valid.
REQ-030 i_flush SHALL load a bubble on the next edge regardless of o_ready and force state IDLE, aborting any multiply; flush wins over capture.
REQ-031 Multiply operands of zero or all-ones SHALL need no special-case timing.

Reset
REQ-032 reset SHALL asynchronously clear ID/EX register (all fields 0, valid 0), multiplier registers, counter; state IDLE.
REQ-033 During and after reset until first capture: o_valid=0, o_ready=1, all outputs 0.
REQ-034 reset mid-multiply SHALL abandon it with no o_valid pulse.

Structure
REQ-035 A shared package misc_v_pkg SHALL hold ALU opcode constants, forward-select encodings and the FSM state type.
REQ-036 The iterative multiplier SHALL be one sub-module, mul_iter (start, A, B -> busy, done, product).

Verification
REQ-037 WIDTH=16: capture add A=0x7FFF B=0x0001 -> next cycle o_result=0x8000, o_valid=1.
REQ-038 fwd1_sel=0, fwd_mem=0x1234, sub B=imm 0x0034 with i_alusrc=1 -> o_result=0x1200.
REQ-039 mul 0x00FF*0x0101, fwd_mem toggled during BUSY -> o_ready low 17 cycles, o_valid at cycle 18 with o_result=0xFFFF.
REQ-040 i_flush asserted in 5th BUSY cycle -> IDLE next cycle, no o_valid, o_ready=1.
REQ-041 reset asserted mid-multiply, released -> all outputs 0, o_ready=1, next instruction executes normally.
REQ-042 WIDTH=8 rerun of REQ-039 with 0x0F*0x11 -> o_result=0xFF after 10 cycles.
